rmst_fm_tile_ld_ctrl: RTL

- Read-master controller that loads one input-feature-map tile per `load_start`, for any kernel size and stride.
- Tile extents are clipped at the feature-map borders. Rows longer than the max burst are split into several avalon bursts.
- Sits between the layer tile scheduler (tile base coordinates) and the avalon read master (param/trans handshake). Feeds the input-FM load FIFO.

---
 rtl/rmst_fm_tile_ld_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rmst_fm_tile_ld_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rmst_fm_tile_ld_ctrl
//  Purpose  : Read-master controller that loads one input-feature-map tile
//             per load_start. The tile extents are clipped at the feature-map
//             borders. Each (channel, row) line is split into Avalon bursts of
//             at most MAX_BURST words, issued in chunk -> row -> channel order.
//  Ports    :
//    clk, rst               clock, asynchronous active-high reset
//    load_start             start a tile load (only accepted in IDLE)
//    load_done              one-cycle pulse when the tile is complete
//    load_busy              high while the controller is not idle
//    tile_base_m/row/col    tile base coordinates, sampled in CALC
//    param_raddr            burst byte address (registered)
//    param_iolen            burst length in words (registered)
//    load_trans_start       one-cycle burst start pulse
//    load_trans_done        burst complete from the read master
//    load_fifo_almost_full  backpressure from the input-FM load FIFO
//    trans_cnt              bursts issued for the current tile
//  Revision : 1.0 - initial release
// ============================================================================
module rmst_fm_tile_ld_ctrl #(
  parameter int CW         = 16,
  parameter int XAW        = 32,
  parameter int DW         = 32,
  parameter int M          = 32,
  parameter int R          = 128,
  parameter int C          = 64,
  parameter int K          = 3,
  parameter int S          = 1,
  parameter int Tm         = 16,
  parameter int Tr         = 64,
  parameter int Tc         = 16,
  parameter int MAX_BURST  = 32,
  parameter int IN_FM_BASE = 65536
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_start,
  output logic           load_done,
  output logic           load_busy,
  input  logic [CW-1:0]  tile_base_m,
  input  logic [CW-1:0]  tile_base_row,
  input  logic [CW-1:0]  tile_base_col,
  output logic [XAW-1:0] param_raddr,
  output logic [CW-1:0]  param_iolen,
  output logic           load_trans_start,
  input  logic           load_trans_done,
  input  logic           load_fifo_almost_full,
  output logic [CW-1:0]  trans_cnt
);

  localparam int BPW    = DW / 8;
  localparam int BPW_SH = $clog2(BPW);
  localparam int TIN_R  = (Tr - 1) * S + K;
  localparam int TIN_C  = (Tc - 1) * S + K;

  localparam logic [CW-1:0]  c_M     = CW'(M);
  localparam logic [CW-1:0]  c_R     = CW'(R);
  localparam logic [CW-1:0]  c_C     = CW'(C);
  localparam logic [CW-1:0]  c_TM    = CW'(Tm);
  localparam logic [CW-1:0]  c_TIN_R = CW'(TIN_R);
  localparam logic [CW-1:0]  c_TIN_C = CW'(TIN_C);
  localparam logic [CW-1:0]  c_MB    = CW'(MAX_BURST);
  localparam logic [CW-1:0]  c_ONE   = CW'(1);
  localparam logic [XAW-1:0] c_BASE  = XAW'(IN_FM_BASE);
  localparam logic [XAW-1:0] c_RC    = XAW'(R * C);
  localparam logic [XAW-1:0] c_CX    = XAW'(C);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    WAIT   = 3'd2,
    CONFIG = 3'd3,
    TRANS  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_bm, r_br, r_bc;
  logic [CW-1:0]  r_ch_eff, r_rows_eff, r_cols_eff;
  logic [CW-1:0]  r_ch, r_row, r_col_off;   // r_col_off = chunk * MAX_BURST
  logic           r_last;                   // burst just finished was the tile's final one
  logic           r_load_done;
  logic           r_trans_start;
  logic [XAW-1:0] r_raddr;
  logic [CW-1:0]  r_iolen;
  logic [CW-1:0]  r_trans_cnt;

  // --------------------------------------------------------------------------
  // Clipped extents. A base at or beyond a border yields extent 0 (empty tile).
  // --------------------------------------------------------------------------
  logic [CW-1:0] w_ch_rem, w_row_rem, w_col_rem;
  logic [CW-1:0] w_ch_eff, w_rows_eff, w_cols_eff;
  logic          w_empty;

  always_comb begin
    w_ch_rem   = c_M - tile_base_m;
    w_row_rem  = c_R - tile_base_row;
    w_col_rem  = c_C - tile_base_col;
    w_ch_eff   = '0;
    w_rows_eff = '0;
    w_cols_eff = '0;
    if (tile_base_m < c_M)
      w_ch_eff = (w_ch_rem < c_TM) ? w_ch_rem : c_TM;
    if (tile_base_row < c_R)
      w_rows_eff = (w_row_rem < c_TIN_R) ? w_row_rem : c_TIN_R;
    if (tile_base_col < c_C)
      w_cols_eff = (w_col_rem < c_TIN_C) ? w_col_rem : c_TIN_C;
    w_empty = (w_ch_eff == '0) || (w_rows_eff == '0) || (w_cols_eff == '0);
  end

  // --------------------------------------------------------------------------
  // Burst address / length for the current (channel, row, chunk). All address
  // terms are evaluated at XAW width and wrap naturally.
  // --------------------------------------------------------------------------
  logic [XAW-1:0] w_ch_term, w_row_term, w_word, w_raddr;
  logic [CW-1:0]  w_rem, w_iolen;
  logic           w_last_chunk, w_last_row, w_last_ch;

  always_comb begin
    w_ch_term  = (XAW'(r_bm) + XAW'(r_ch)) * c_RC;
    w_row_term = (XAW'(r_br) + XAW'(r_row)) * c_CX;
    w_word     = c_BASE + w_ch_term + w_row_term + XAW'(r_bc) + XAW'(r_col_off);
    w_raddr    = w_word << BPW_SH;
    // r_col_off is always below r_cols_eff, so w_rem is non-zero here.
    w_rem        = r_cols_eff - r_col_off;
    w_iolen      = (w_rem > c_MB) ? c_MB : w_rem;
    w_last_chunk = (w_rem <= c_MB);
    w_last_row   = (r_row == (r_rows_eff - c_ONE));
    w_last_ch    = (r_ch == (r_ch_eff - c_ONE));
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_bm          <= '0;
      r_br          <= '0;
      r_bc          <= '0;
      r_ch_eff      <= '0;
      r_rows_eff    <= '0;
      r_cols_eff    <= '0;
      r_ch          <= '0;
      r_row         <= '0;
      r_col_off     <= '0;
      r_last        <= 1'b0;
      r_load_done   <= 1'b0;
      r_trans_start <= 1'b0;
      r_raddr       <= '0;
      r_iolen       <= '0;
      r_trans_cnt   <= '0;
    end else begin
      r_load_done   <= 1'b0;
      r_trans_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_start)
            r_state <= CALC;
        end

        CALC: begin
          r_bm        <= tile_base_m;
          r_br        <= tile_base_row;
          r_bc        <= tile_base_col;
          r_ch_eff    <= w_ch_eff;
          r_rows_eff  <= w_rows_eff;
          r_cols_eff  <= w_cols_eff;
          r_ch        <= '0;
          r_row       <= '0;
          r_col_off   <= '0;
          r_last      <= 1'b0;
          r_trans_cnt <= '0;
          if (w_empty) begin
            r_state     <= IDLE;
            r_load_done <= 1'b1;
          end else if (load_fifo_almost_full) begin
            r_state <= WAIT;
          end else begin
            r_state <= CONFIG;
          end
        end

        WAIT: begin
          if (!load_fifo_almost_full)
            r_state <= CONFIG;
        end

        CONFIG: begin
          r_raddr       <= w_raddr;
          r_iolen       <= w_iolen;
          r_trans_start <= 1'b1;
          r_trans_cnt   <= r_trans_cnt + c_ONE;
          r_state       <= TRANS;
        end

        TRANS: begin
          if (load_trans_done) begin
            r_last  <= w_last_chunk && w_last_row && w_last_ch;
            r_state <= DONE;
            if (w_last_chunk) begin
              r_col_off <= '0;
              if (w_last_row) begin
                r_row <= '0;
                r_ch  <= r_ch + c_ONE;
              end else begin
                r_row <= r_row + c_ONE;
              end
            end else begin
              r_col_off <= r_col_off + c_MB;
            end
          end
        end

        DONE: begin
          if (r_last) begin
            r_state     <= IDLE;
            r_load_done <= 1'b1;
            r_last      <= 1'b0;
            r_ch        <= '0;
            r_row       <= '0;
            r_col_off   <= '0;
          end else if (load_fifo_almost_full) begin
            r_state <= WAIT;
          end else begin
            r_state <= CONFIG;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign load_done        = r_load_done;
  assign load_busy        = (r_state != IDLE);
  assign param_raddr      = r_raddr;
  assign param_iolen      = r_iolen;
  assign load_trans_start = r_trans_start;
  assign trans_cnt        = r_trans_cnt;

endmodule
`default_nettype wire
